fire_expand3_sched: RTL and testbench
=====================================

Name: fire_expand3_sched

Overview:
- Sequencer for the shared 128-MAC expand-3x3 array used by fire4 and fire5.
- On `start`, runs fire4 expand-3x3 to completion, waits for the RAM write-back acknowledge, then runs fire5 the same way.
- Drives the layer enables, weight ROM address, MAC clear pulse, output sample strobe and per-layer finish flags.
- Replaces the free-running counters inside the datapath with one explicit FSM that has an input-valid stall.

Parameters:
- WOUT, 32, output feature map width/height; pixels per layer = WOUT**2
- CHIN, 32, input channels
- KERNEL_DIM, 3, kernel window dimension
- CLR_LAT, 2, cycles from the accept of the last tap to `mac_clr` (kernel register plus MAC pipeline); legal range 1..4
- MAC_LEN, KERNEL_DIM**2*CHIN (288), derived localparam; taps per output pixel

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins the fire4-then-fire5 sequence
- ifm_valid  in  1  input pixel word present this cycle; taps advance only when high
- ram_feedback_4  in  1  fire4 output RAM has absorbed all pixels (level or pulse)
- ram_feedback_5  in  1  same, for fire5
- fire4_expand_3_en  out  1  fire4 layer active (selects fire4 ROM, bias and ifm)
- fire5_expand_3_en  out  1  fire5 layer active
- weight_rom_address  out  $clog2(MAC_LEN)  tap index 0..MAC_LEN-1
- mac_layer_en  out  1  en delayed by one cycle (MAC enable)
- mac_clr  out  1  one-cycle pulse; MAC result complete, bias, ReLU and capture now
- ofm_sample  out  1  `mac_clr` delayed by one cycle; RAM write strobe
- pixel_index  out  $clog2(WOUT**2)  index of the pixel captured at `mac_clr`
- fire4_expand_3_finish  out  1  fire4 done, awaiting RAM ack
- fire5_expand_3_finish  out  1  fire5 done, awaiting RAM ack
- busy  out  1  FSM not IDLE and not DONE
- done  out  1  one-cycle pulse when fire5 is acknowledged

Behaviour:
- **Reset:** async on `rst`=1. All outputs are 0, the FSM is in IDLE and all counters are 0.
- **FSM states:** IDLE, RUN4, DRAIN4, ACK4, RUN5, DRAIN5, ACK5.
- **IDLE:**
  - `start` moves to RUN4 on the next clock.
  - `start` is ignored in every other state.
- **RUNx (x = 4 or 5):**
  - `fireX_expand_3_en`=1.
  - A tap is accepted on each cycle with `ifm_valid`=1; each accept increments `weight_rom_address`.
  - The accept of tap MAC_LEN-1 wraps the address to 0 on the same edge.
  - `ifm_valid`=0 holds the address and freezes the tap count; `mac_layer_en` still follows en.
- **Clear pulse:**
  - `mac_clr` asserts exactly CLR_LAT cycles after each last-tap accept, for exactly one cycle.
  - Uses a CLR_LAT-deep shift register and is independent of later stalls.
- **Pixel count:**
  - `pixel_index` increments on the cycle after `mac_clr`.
  - The accept of the last tap of pixel WOUT**2-1 moves RUNx to DRAINx.
- **DRAINx:**
  - En stays 1 so the datapath mux keeps layer x.
  - No new taps are accepted.
  - Leave for ACKx on the cycle after `ofm_sample` of the final pixel.
- **ACKx:**
  - En=0 and `fireX_expand_3_finish`=1.
  - `ram_feedback_x`=1 clears finish and moves to RUN5 (from ACK4) or to IDLE with `done`=1 (from ACK5).
  - `pixel_index` resets to 0 when leaving ACKx.
- **En rules:** `fire4_expand_3_en` and `fire5_expand_3_en` are never 1 together.
- **Feedback timing:** feedback that arrives before ACKx is ignored and is not latched. A RAM that pulses early must re-pulse.
- **Reset mid-layer:**
  - Aborts immediately: en and `mac_clr` drop asynchronously and the `mac_clr` pipeline is flushed.
  - No `ofm_sample` is issued after reset deasserts.
- **Counter widths:** the address counter is sized to MAC_LEN-1 and the pixel counter to WOUT**2-1. Neither may overflow; wrap happens at the terminal count.

Optional Feature:
- **Macro:** SCHED_PERF_CNT_EN.
- **With the macro defined:**
  - Adds two outputs, `stall_cycles` [31:0] and `layer_cycles` [31:0].
  - `layer_cycles` counts every cycle in RUN or DRAIN; `stall_cycles` counts RUN cycles with `ifm_valid`=0.
  - Both clear on `start` accepted and saturate at 0xFFFFFFFF.
- **Without the macro:** the ports and logic are absent.

Decomposition:
- **Package `fire_sched_pkg`:**
  - `state_t` enum.
  - MAC_LEN and pixel-count localparam functions.
  - `layer_sel_t` (FIRE4 / FIRE5).
- **Sub-module `sched_tap_counter`:**
  - Parameterised modulo counter with enable, terminal-count flag and sync clear.
  - Instantiated twice: taps and pixels.
- The CLR_LAT shift register stays inline.

Test Plan:
- **Nominal run:** WOUT=2, CHIN=2 (MAC_LEN=18), `ifm_valid` always 1, `start` at cycle 5.
  - Address cycles 0..17 four times per layer.
  - `mac_clr` fires 4 times per layer, CLR_LAT=2 cycles after each address-17 accept; `ofm_sample` 1 cycle later.
  - `fire4_expand_3_finish` asserts 1 cycle after the 4th sample.
- **Stall:** `ifm_valid` low for 3 cycles at tap 17.
  - Address holds at 17 for 3 cycles.
  - `mac_clr` is delayed by exactly 3 cycles.
  - With SCHED_PERF_CNT_EN, `stall_cycles` = 3.
- **Feedback handshake:** `ram_feedback_4` pulsed during RUN4, then held low 10 cycles in ACK4, then pulsed.
  - The early pulse is ignored.
  - Finish stays high for 10 cycles.
  - `fire5_expand_3_en` rises the cycle after the accepted pulse.
  - The two en signals never overlap.
- **Reset mid-operation:** `rst` asserted at tap 10 of pixel 2 in RUN5.
  - All outputs go to 0 asynchronously; the FSM returns to IDLE.
  - No `mac_clr` or `ofm_sample` appears after release.
  - A fresh `start` restarts at fire4 pixel 0.
- **Spurious start:** `start` pulsed while busy in RUN4 and again in ACK5.
  - Both pulses are ignored.
  - `done` pulses exactly once at the end of fire5.

Source files
------------

// File: rtl/fire_sched_pkg.sv
// Shared types and sizing helpers for the fire4/fire5 expand-3x3 sequencer.
package fire_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRun4,
        StDrain4,
        StAck4,
        StRun5,
        StDrain5,
        StAck5
    } state_t;

    typedef enum logic {
        Fire4 = 1'b0,
        Fire5 = 1'b1
    } layer_sel_t;

    function automatic int unsigned mac_len(input int unsigned kernel_dim,
                                            input int unsigned chin);
        return kernel_dim * kernel_dim * chin;
    endfunction

    function automatic int unsigned pixel_count(input int unsigned wout);
        return wout * wout;
    endfunction

    // Counter width that still yields a legal vector when the modulus is 1.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

    function automatic layer_sel_t state_layer(input state_t st);
        if (st inside {StRun5, StDrain5, StAck5}) begin
            return Fire5;
        end
        return Fire4;
    endfunction

endpackage

// File: rtl/sched_tap_counter.sv
// Modulo counter with enable, sync clear and terminal-count flag; used for taps and pixels.
module sched_tap_counter #(
    parameter int unsigned Modulus = 2,
    parameter int unsigned Width   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic             tc
);

    localparam logic [Width-1:0] Last = Width'(Modulus - 1);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tc ? '0 : count_q + Width'(1);
        end
    end

    assign count = count_q;
    assign tc    = (count_q == Last);

endmodule

// File: rtl/fire_expand3_sched.sv
// Sequencer for the shared expand-3x3 MAC array: fire4, RAM ack, fire5, RAM ack.
// Optional build macro SCHED_PERF_CNT_EN adds stall_cycles / layer_cycles counters.
module fire_expand3_sched
    import fire_sched_pkg::*;
#(
    parameter int unsigned WOUT       = 32,
    parameter int unsigned CHIN       = 32,
    parameter int unsigned KERNEL_DIM = 3,
    parameter int unsigned CLR_LAT    = 2
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               start,
    input  logic                                               ifm_valid,
    input  logic                                               ram_feedback_4,
    input  logic                                               ram_feedback_5,
    output logic                                               fire4_expand_3_en,
    output logic                                               fire5_expand_3_en,
    output logic [cnt_width(mac_len(KERNEL_DIM, CHIN))-1:0]    weight_rom_address,
    output logic                                               mac_layer_en,
    output logic                                               mac_clr,
    output logic                                               ofm_sample,
    output logic [cnt_width(pixel_count(WOUT))-1:0]            pixel_index,
    output logic                                               fire4_expand_3_finish,
    output logic                                               fire5_expand_3_finish,
    output logic                                               busy,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]                                        stall_cycles,
    output logic [31:0]                                        layer_cycles,
`endif
    output logic                                               done
);

    localparam int unsigned MAC_LEN = mac_len(KERNEL_DIM, CHIN);
    localparam int unsigned NPIX    = pixel_count(WOUT);
    localparam int unsigned AW      = cnt_width(MAC_LEN);
    localparam int unsigned PW      = cnt_width(NPIX);

    state_t               state_q;
    logic                 en4_q;
    logic                 en5_q;
    logic                 layer_en_q;
    logic                 smp_q;
    logic                 fin4_q;
    logic                 fin5_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CLR_LAT-1:0]   clr_sr_q;

    layer_sel_t           cur_layer;
    logic                 running;
    logic                 accept;
    logic                 last_tap;
    logic                 feedback;
    logic                 ack_leave;
    logic                 tap_tc;
    logic                 pix_tc;
    logic [AW-1:0]        tap_count;
    logic [PW-1:0]        pix_count;

    always_comb begin
        cur_layer = state_layer(state_q);
        running   = state_q inside {StRun4, StRun5};
        accept    = running & ifm_valid;
        last_tap  = accept & tap_tc;
        feedback  = (cur_layer == Fire5) ? ram_feedback_5 : ram_feedback_4;
        ack_leave = (state_q inside {StAck4, StAck5}) & feedback;
    end

    sched_tap_counter #(
        .Modulus (MAC_LEN),
        .Width   (AW)
    ) u_tap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (accept),
        .count (tap_count),
        .tc    (tap_tc)
    );

    // Counts captures, so it lags the tap stream by CLR_LAT+1 cycles; as a pixel takes at least
    // MAC_LEN (>= 9) cycles, it already names the current pixel by that pixel's last tap.
    sched_tap_counter #(
        .Modulus (NPIX),
        .Width   (PW)
    ) u_pix_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (ack_leave),
        .en    (clr_sr_q[CLR_LAT-1]),
        .count (pix_count),
        .tc    (pix_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            en4_q      <= 1'b0;
            en5_q      <= 1'b0;
            layer_en_q <= 1'b0;
            smp_q      <= 1'b0;
            fin4_q     <= 1'b0;
            fin5_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clr_sr_q   <= '0;
        end else begin
            clr_sr_q   <= CLR_LAT'({clr_sr_q, last_tap});
            smp_q      <= clr_sr_q[CLR_LAT-1];
            layer_en_q <= en4_q | en5_q;
            done_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun4;
                        en4_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StRun4: begin
                    if (last_tap && pix_tc) begin
                        state_q <= StDrain4;
                    end
                end
                StDrain4: begin
                    // The only capture still in flight here is the final pixel's.
                    if (smp_q) begin
                        state_q <= StAck4;
                        en4_q   <= 1'b0;
                        fin4_q  <= 1'b1;
                    end
                end
                StAck4: begin
                    if (ack_leave) begin
                        state_q <= StRun5;
                        fin4_q  <= 1'b0;
                        en5_q   <= 1'b1;
                    end
                end
                StRun5: begin
                    if (last_tap && pix_tc) begin
                        state_q <= StDrain5;
                    end
                end
                StDrain5: begin
                    if (smp_q) begin
                        state_q <= StAck5;
                        en5_q   <= 1'b0;
                        fin5_q  <= 1'b1;
                    end
                end
                StAck5: begin
                    if (ack_leave) begin
                        state_q <= StIdle;
                        fin5_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] layer_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            layer_q <= '0;
        end else if (state_q == StIdle && start) begin
            stall_q <= '0;
            layer_q <= '0;
        end else begin
            if ((state_q inside {StRun4, StRun5, StDrain4, StDrain5}) && layer_q != '1) begin
                layer_q <= layer_q + 32'd1;
            end
            if (running && !ifm_valid && stall_q != '1) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign layer_cycles = layer_q;
`endif

    assign fire4_expand_3_en     = en4_q;
    assign fire5_expand_3_en     = en5_q;
    assign weight_rom_address    = tap_count;
    assign mac_layer_en          = layer_en_q;
    assign mac_clr               = clr_sr_q[CLR_LAT-1];
    assign ofm_sample            = smp_q;
    assign pixel_index           = pix_count;
    assign fire4_expand_3_finish = fin4_q;
    assign fire5_expand_3_finish = fin5_q;
    assign busy                  = busy_q;
    assign done                  = done_q;

endmodule

// File: tb/tb_fire_expand3_sched.sv
// Bench for fire_expand3_sched: cycle model of the layer schedule plus directed scenarios.
module tb_fire_expand3_sched;

    localparam int MAC_LEN = 18;
    localparam int NPIX    = 4;
    localparam int CLR_LAT = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ifm_valid;
    logic       fb4;
    logic       fb5;
    logic       en4;
    logic       en5;
    logic [4:0] addr;
    logic       lay_en;
    logic       mac_clr;
    logic       ofm_sample;
    logic [1:0] pix;
    logic       fin4;
    logic       fin5;
    logic       busy;
    logic       done;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] layer_cycles;
`endif

    fire_expand3_sched #(
        .WOUT       (2),
        .CHIN       (2),
        .KERNEL_DIM (3),
        .CLR_LAT    (CLR_LAT)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .ifm_valid             (ifm_valid),
        .ram_feedback_4        (fb4),
        .ram_feedback_5        (fb5),
        .fire4_expand_3_en     (en4),
        .fire5_expand_3_en     (en5),
        .weight_rom_address    (addr),
        .mac_layer_en          (lay_en),
        .mac_clr               (mac_clr),
        .ofm_sample            (ofm_sample),
        .pixel_index           (pix),
        .fire4_expand_3_finish (fin4),
        .fire5_expand_3_finish (fin5),
        .busy                  (busy),
`ifdef SCHED_PERF_CNT_EN
        .stall_cycles          (stall_cycles),
        .layer_cycles          (layer_cycles),
`endif
        .done                  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tb_cyc = 0;
    initial forever begin
        @(posedge clk);
        tb_cyc = tb_cyc + 1;
    end

    // Behavioural schedule model: phase 0 idle, 1 taps, 2 drain, 3 waiting for RAM ack.
    int          m_phase = 0;
    int          m_layer = 0;
    int          m_tap = 0;
    int          m_issued = 0;
    int          m_samples = 0;
    int          m_pix = 0;
    int          m_cyc = 0;
    int          clr_due[$];
    bit          e_en4 = 0, e_en5 = 0, e_lay = 0, e_clr = 0, e_smp = 0;
    bit          e_f4 = 0, e_f5 = 0, e_busy = 0, e_done = 0;
    int          e_addr = 0, e_pix = 0;
    int unsigned e_stall = 0, e_lcyc = 0;

    task automatic model_reset();
        m_phase = 0; m_layer = 0; m_tap = 0; m_issued = 0; m_samples = 0; m_pix = 0;
        clr_due.delete();
        e_en4 = 0; e_en5 = 0; e_lay = 0; e_clr = 0; e_smp = 0;
        e_f4 = 0; e_f5 = 0; e_busy = 0; e_done = 0; e_addr = 0; e_pix = 0;
        e_stall = 0; e_lcyc = 0;
    endtask

    task automatic model_step();
        bit prev_clr;
        bit prev_en;
        bit acc;
        prev_clr = e_clr;
        prev_en  = e_en4 | e_en5;
        acc      = (m_phase == 1) && ifm_valid;
        if ((m_phase == 1 || m_phase == 2) && e_lcyc != 32'hFFFF_FFFF) e_lcyc++;
        if (m_phase == 1 && !ifm_valid && e_stall != 32'hFFFF_FFFF) e_stall++;
        if (acc) begin
            if (m_tap == MAC_LEN - 1) begin
                m_tap = 0;
                m_issued++;
                clr_due.push_back(m_cyc + CLR_LAT);
            end else begin
                m_tap++;
            end
        end
        if (prev_clr) m_pix = (m_pix + 1) % NPIX;
        if (e_smp) m_samples++;
        e_done = 0;
        case (m_phase)
            0: if (start) begin
                m_phase = 1; m_layer = 4; e_stall = 0; e_lcyc = 0;
            end
            1: if (m_issued == NPIX) m_phase = 2;
            2: if (m_samples == NPIX) m_phase = 3;
            3: if ((m_layer == 4 && fb4) || (m_layer == 5 && fb5)) begin
                m_pix = 0; m_issued = 0; m_samples = 0;
                if (m_layer == 4) begin
                    m_layer = 5; m_phase = 1;
                end else begin
                    m_layer = 0; m_phase = 0; e_done = 1;
                end
            end
            default: m_phase = 0;
        endcase
        m_cyc++;
        e_clr = 0;
        if (clr_due.size() > 0 && clr_due[0] == m_cyc) begin
            e_clr = 1;
            void'(clr_due.pop_front());
        end
        e_smp  = prev_clr;
        e_lay  = prev_en;
        e_addr = m_tap;
        e_pix  = m_pix;
        e_en4  = (m_layer == 4) && (m_phase == 1 || m_phase == 2);
        e_en5  = (m_layer == 5) && (m_phase == 1 || m_phase == 2);
        e_f4   = (m_layer == 4) && (m_phase == 3);
        e_f5   = (m_layer == 5) && (m_phase == 3);
        e_busy = (m_phase != 0);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else model_step();
    end

    // Observation log used by the hand-computed checks.
    int clr_q[$];
    int smp_q[$];
    int done_cnt = 0;
    int fin4_run = 0;
    int fin4_len = 0;
    initial forever begin
        @(negedge clk);
        if (mac_clr) clr_q.push_back(tb_cyc);
        if (ofm_sample) smp_q.push_back(tb_cyc);
        if (done) done_cnt++;
        if (fin4) begin
            fin4_run++;
        end else if (fin4_run != 0) begin
            fin4_len = fin4_run;
            fin4_run = 0;
        end
    end

    int n_total = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, tb_cyc);
        end
    endtask

    task automatic compare_all();
        chk("en4", en4, e_en4);
        chk("en5", en5, e_en5);
        chk("addr", addr, e_addr);
        chk("mac_layer_en", lay_en, e_lay);
        chk("mac_clr", mac_clr, e_clr);
        chk("ofm_sample", ofm_sample, e_smp);
        chk("pixel_index", pix, e_pix);
        chk("finish4", fin4, e_f4);
        chk("finish5", fin5, e_f5);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("en_overlap", en4 & en5, 0);
`ifdef SCHED_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, e_stall);
        chk("layer_cycles", layer_cycles, e_lcyc);
`endif
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_start(output int s);
        start = 1'b1;
        s = tb_cyc;
        tick();
        start = 1'b0;
    endtask

    function automatic bit sig_sel(input int which);
        case (which)
            0: return fin4;
            1: return fin5;
            2: return en4 && addr == 5'd17;
            default: return en5 && pix == 2'd2 && addr == 5'd10;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name);
        int n = 0;
        while (!sig_sel(which) && n < budget) begin
            tick();
            n++;
        end
        chk(name, sig_sel(which), 1);
    endtask

    task automatic pulse_fb(input int layer);
        if (layer == 4) fb4 = 1'b1; else fb5 = 1'b1;
        tick();
        fb4 = 1'b0;
        fb5 = 1'b0;
    endtask

    initial begin
        int s;
        int c0;
        int sm0;
        int d0;
        rst = 1'b1;
        start = 1'b0;
        ifm_valid = 1'b1;
        fb4 = 1'b0;
        fb5 = 1'b0;
        tick();
        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none
        tick();
        chk("rst_en4", en4, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", addr, 0);
        rst = 1'b0;
        while (tb_cyc < 5) tick();

        // Nominal run with spurious starts in RUN4 and ACK5.
        d0 = done_cnt;
        c0 = clr_q.size();
        do_start(s);
        tick(30);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("spur_start_run4_en4", en4, 1);
        wait_for(0, 300, "nom_fin4_seen");
        chk("nom_clr4_count", clr_q.size() - c0, 4);
        chk("nom_first_clr", clr_q[c0] - s, 20);
        chk("nom_clr_spacing", clr_q[c0 + 1] - clr_q[c0], 18);
        chk("nom_fin4_after_smp", tb_cyc - smp_q[$], 1);
        pulse_fb(4);
        chk("nom_en5_up", en5, 1);
        wait_for(1, 300, "nom_fin5_seen");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("spur_start_ack5_fin5", fin5, 1);
        chk("nom_clr8_count", clr_q.size() - c0, 8);
        pulse_fb(5);
        chk("nom_done_pulse", done, 1);
        tick(3);
        chk("nom_done_once", done_cnt - d0, 1);
        chk("nom_idle_busy", busy, 0);

        // Stall at tap 17 plus early feedback pulses and a delayed RAM ack.
        c0 = clr_q.size();
        do_start(s);
        wait_for(2, 40, "stall_tap17_seen");
        chk("stall_tap17_cycle", tb_cyc - s, 18);
        ifm_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_addr_hold", addr, 17);
            tick();
        end
        chk("stall_addr_after", addr, 17);
        ifm_valid = 1'b1;
        tick(5);
        fb4 = 1'b1;
        fb5 = 1'b1;
        tick();
        fb4 = 1'b0;
        fb5 = 1'b0;
        chk("early_fb_ignored", en4, 1);
        wait_for(0, 300, "stall_fin4_seen");
        chk("stall_first_clr", clr_q[c0] - s, 23);
        tick(9);
        chk("ack_wait_fin4", fin4, 1);
        chk("ack_wait_en5", en5, 0);
        fb4 = 1'b1;
        tick();
        fb4 = 1'b0;
        chk("ack_en5_up", en5, 1);
        chk("ack_fin4_clear", fin4, 0);
        tick();
        chk("ack_fin4_len", fin4_len, 10);
        wait_for(1, 300, "stall_fin5_seen");
        pulse_fb(5);
        tick(2);
`ifdef SCHED_PERF_CNT_EN
        chk("perf_stall", stall_cycles, 3);
        chk("perf_layer", layer_cycles, 153);
`endif

        // Reset at tap 10 of pixel 2 in fire5, then a clean restart.
        do_start(s);
        wait_for(0, 300, "rst_fin4_seen");
        pulse_fb(4);
        wait_for(3, 300, "rst_point_seen");
        rst = 1'b1;
        #1;
        chk("arst_en5", en5, 0);
        chk("arst_mac_clr", mac_clr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pix", pix, 0);
        chk("arst_addr", addr, 0);
        tick(2);
        rst = 1'b0;
        c0 = clr_q.size();
        sm0 = smp_q.size();
        tick(30);
        chk("post_rst_no_clr", clr_q.size() - c0, 0);
        chk("post_rst_no_smp", smp_q.size() - sm0, 0);
        chk("post_rst_busy", busy, 0);
        d0 = done_cnt;
        do_start(s);
        chk("restart_en4", en4, 1);
        wait_for(0, 300, "restart_fin4_seen");
        chk("restart_first_clr", clr_q[c0] - s, 20);
        chk("restart_clr_count", clr_q.size() - c0, 4);
        pulse_fb(4);
        wait_for(1, 300, "restart_fin5_seen");
        pulse_fb(5);
        tick(3);
        chk("restart_done_once", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
